// File: rtl/mcs8_bus_pkg.sv
// Shared encodings for the 8008 bus responder: CPU T-state codes, cycle types, FSM states.
package mcs8_bus_pkg;

  // CPU state lines S2..S0
  typedef enum logic [2:0] {
    S_WAIT = 3'b000,
    S_T3   = 3'b001,
    S_T1   = 3'b010,
    S_STOP = 3'b011,
    S_T2   = 3'b100,
    S_T5   = 3'b101,
    S_T1I  = 3'b110,
    S_T4   = 3'b111
  } s_state_t;

  // Cycle type carried in D[7:6] during T2
  typedef enum logic [1:0] {
    CYC_PCI = 2'b00,  // instruction fetch
    CYC_PCR = 2'b01,  // memory read
    CYC_PCC = 2'b10,  // I/O command
    CYC_PCW = 2'b11   // memory write
  } cyc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADRL,
    ST_REQ,
    ST_DATA,
    ST_PWR
  } fsm_t;

  // I/O ports 0..7 are inputs; any nonzero hi[5:4] addresses an output port
  function automatic logic io_is_out(input logic [5:0] hi);
    return hi[5:4] != 2'b00;
  endfunction

endpackage

// File: rtl/mcs8_ack_timer.sv
// Acknowledge watchdog: counts CPU sample edges while armed and pulses expire on the last one.
module mcs8_ack_timer #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic CLK2_I,
  input  logic nRST_I,
  input  logic load,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int unsigned CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt;

  // Reload while disarmed, stop on acknowledge, otherwise count down once per sample edge
  always_ff @(posedge CLK2_I or negedge nRST_I) begin
    if (!nRST_I) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TMO_CYC);
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // A zero timeout never expires; the count parks at zero after firing
  assign expire = (TMO_CYC != 0) && !load && !clr && tick && (cnt == CW'(1));

endmodule

// File: rtl/mcs8_bus_responder.sv
// System-side responder for the 8008 multiplexed bus: address latching, memory/I/O handshake,
// READY stretching, read-data drive, one-deep posted writes and interrupt vector jamming.
module mcs8_bus_responder
  import mcs8_bus_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255,
  parameter logic [7:0]  TMO_DAT = 8'hFF
) (
  input  logic        CLK2_I,
  input  logic        nRST_I,
  input  logic        SYNC_I,
  input  logic [2:0]  S_I,
  input  logic [7:0]  D_I,
  output logic [7:0]  D_O,
  output logic        D_OE_O,
  output logic        READY_O,
  input  logic [7:0]  INT_VEC_I,
  output logic [13:0] ADDR_O,
  output logic        RD_O,
  output logic        WR_O,
  output logic        IO_O,
  output logic [4:0]  IO_PORT_O,
  output logic        IO_OUT_O,
  output logic [7:0]  WDAT_O,
  input  logic [7:0]  RDAT_I,
  input  logic        ACK_I
);

  fsm_t       state;
  logic [7:0] lo;
  logic [5:0] hi;
  cyc_t       cyc;
  logic [7:0] rdat;
  logic       int_fetch;
  logic       launch;   // a cycle queued behind a posted write is dispatched without a T2 edge
  logic       pend_t1;  // new cycle's T1 seen while a write is posted
  logic       pend_t2;  // ... and its T2 as well

  s_state_t   s;
  logic       samp_t1, samp_t2, disp_now, req_done, read_type;
  logic       tmo_load, tmo_expire;
  cyc_t       disp_cyc;
  logic [5:0] disp_hi;

  assign s         = s_state_t'(S_I);
  assign samp_t1   = SYNC_I && (s == S_T1 || s == S_T1I);
  assign samp_t2   = SYNC_I && (s == S_T2);
  assign disp_now  = (state == ST_ADRL) && (launch || samp_t2);
  assign disp_cyc  = launch ? cyc : cyc_t'(D_I[7:6]);
  assign disp_hi   = launch ? hi : D_I[5:0];
  assign read_type = (cyc != CYC_PCW) && !(cyc == CYC_PCC && io_is_out(hi));
  assign req_done  = ACK_I || tmo_expire;
  assign tmo_load  = !(state == ST_REQ || state == ST_PWR);

  assign ADDR_O    = {hi, lo};
  assign IO_PORT_O = hi[5:1];
  assign IO_OUT_O  = io_is_out(hi);

  mcs8_ack_timer #(.TMO_CYC(TMO_CYC)) u_timer (
    .CLK2_I (CLK2_I),
    .nRST_I (nRST_I),
    .load   (tmo_load),
    .clr    (ACK_I),
    .tick   (SYNC_I),
    .expire (tmo_expire)
  );

  // Bus-cycle FSM: tracks T-states, runs the request handshake and owns every registered output
  always_ff @(posedge CLK2_I or negedge nRST_I) begin
    if (!nRST_I) begin
      state     <= ST_IDLE;
      lo        <= '0;
      hi        <= '0;
      cyc       <= CYC_PCI;
      rdat      <= '0;
      int_fetch <= 1'b0;
      launch    <= 1'b0;
      pend_t1   <= 1'b0;
      pend_t2   <= 1'b0;
      D_O       <= '0;
      D_OE_O    <= 1'b0;
      READY_O   <= 1'b1;
      RD_O      <= 1'b0;
      WR_O      <= 1'b0;
      IO_O      <= 1'b0;
      WDAT_O    <= '0;
    end else begin
      // NOTE: non-blocking assignments let this default release be overridden later in the
      // same block (T3 read drive); the last scheduled value wins at the clock edge.
      if (SYNC_I && s != S_T3) D_OE_O <= 1'b0;

      if (state == ST_PWR) begin
        if (req_done) begin
          WR_O    <= 1'b0;
          pend_t1 <= 1'b0;
          pend_t2 <= 1'b0;
          if (samp_t2 && pend_t1) begin
            // completion wins; the new cycle is dispatched on the next clock
            hi     <= D_I[5:0];
            cyc    <= cyc_t'(D_I[7:6]);
            launch <= 1'b1;
            state  <= ST_ADRL;
          end else if (samp_t1) begin
            lo        <= D_I;
            int_fetch <= (s == S_T1I);
            state     <= ST_ADRL;
          end else if (pend_t2) begin
            launch <= 1'b1;
            state  <= ST_ADRL;
          end else if (pend_t1) begin
            state <= ST_ADRL;
          end else begin
            state <= ST_IDLE;
          end
        end else if (samp_t1) begin
          lo        <= D_I;
          int_fetch <= (s == S_T1I);
          pend_t1   <= 1'b1;
          pend_t2   <= 1'b0;
        end else if (samp_t2 && pend_t1) begin
          hi      <= D_I[5:0];
          cyc     <= cyc_t'(D_I[7:6]);
          pend_t2 <= 1'b1;
          READY_O <= 1'b0;
        end else if (SYNC_I && s == S_STOP) begin
          // the posted write itself is kept; only the queued cycle is abandoned
          pend_t1 <= 1'b0;
          pend_t2 <= 1'b0;
          READY_O <= 1'b1;
        end
      end else if (disp_now) begin
        launch <= 1'b0;
        hi     <= disp_hi;
        cyc    <= disp_cyc;
        case (disp_cyc)
          CYC_PCI, CYC_PCR: begin
            if (disp_cyc == CYC_PCI && int_fetch) begin
              rdat    <= INT_VEC_I;
              READY_O <= 1'b1;
              state   <= ST_DATA;
            end else begin
              RD_O    <= 1'b1;
              READY_O <= 1'b0;
              state   <= ST_REQ;
            end
          end
          CYC_PCC: begin
            IO_O <= 1'b1;
            if (io_is_out(disp_hi)) WDAT_O <= lo;
            READY_O <= 1'b0;
            state   <= ST_REQ;
          end
          CYC_PCW: begin
            READY_O <= 1'b1;
            state   <= ST_DATA;
          end
        endcase
      end else if (samp_t1) begin
        lo        <= D_I;
        int_fetch <= (s == S_T1I);
        RD_O      <= 1'b0;
        IO_O      <= 1'b0;
        READY_O   <= 1'b1;
        state     <= ST_ADRL;
      end else begin
        case (state)
          ST_ADRL: begin
            if (SYNC_I && s != S_WAIT) begin
              RD_O    <= 1'b0;
              IO_O    <= 1'b0;
              D_OE_O  <= 1'b0;
              READY_O <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          ST_REQ: begin
            if (req_done) begin
              rdat    <= ACK_I ? RDAT_I : TMO_DAT;
              RD_O    <= 1'b0;
              IO_O    <= 1'b0;
              READY_O <= 1'b1;
              state   <= ST_DATA;
            end else if (SYNC_I && s != S_WAIT) begin
              RD_O    <= 1'b0;
              IO_O    <= 1'b0;
              D_OE_O  <= 1'b0;
              READY_O <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          ST_DATA: begin
            if (SYNC_I) begin
              if (s == S_T3) begin
                if (cyc == CYC_PCW) begin
                  WDAT_O <= D_I;
                  WR_O   <= 1'b1;
                  state  <= ST_PWR;
                end else begin
                  if (read_type) begin
                    D_OE_O <= 1'b1;
                    D_O    <= rdat;
                  end
                  state <= ST_IDLE;
                end
              end else if (s != S_WAIT) begin
                state <= ST_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcs8_bus_responder.sv
// Directed bench for mcs8_bus_responder: stimulus pushes expected bus events into a scoreboard,
// a negedge monitor pops and compares them as the DUT raises its outputs.
module tb_mcs8_bus_responder;
  import mcs8_bus_pkg::*;

  logic        CLK2_I = 1'b0;
  logic        nRST_I = 1'b0;
  logic        SYNC_I = 1'b0;
  logic [2:0]  S_I = 3'b000;
  logic [7:0]  D_I = 8'h00;
  logic [7:0]  D_O;
  logic        D_OE_O;
  logic        READY_O;
  logic [7:0]  INT_VEC_I = 8'h0D;
  logic [13:0] ADDR_O;
  logic        RD_O, WR_O, IO_O, IO_OUT_O;
  logic [4:0]  IO_PORT_O;
  logic [7:0]  WDAT_O;
  logic [7:0]  RDAT_I = 8'h00;
  logic        ACK_I = 1'b0;

  mcs8_bus_responder #(.TMO_CYC(4), .TMO_DAT(8'hFF)) dut (
    .CLK2_I    (CLK2_I),
    .nRST_I    (nRST_I),
    .SYNC_I    (SYNC_I),
    .S_I       (S_I),
    .D_I       (D_I),
    .D_O       (D_O),
    .D_OE_O    (D_OE_O),
    .READY_O   (READY_O),
    .INT_VEC_I (INT_VEC_I),
    .ADDR_O    (ADDR_O),
    .RD_O      (RD_O),
    .WR_O      (WR_O),
    .IO_O      (IO_O),
    .IO_PORT_O (IO_PORT_O),
    .IO_OUT_O  (IO_OUT_O),
    .WDAT_O    (WDAT_O),
    .RDAT_I    (RDAT_I),
    .ACK_I     (ACK_I)
  );

  always #5 CLK2_I = ~CLK2_I;

  typedef enum logic [2:0] {EV_RD, EV_IO, EV_WR, EV_RDY, EV_DOUT} ev_t;
  typedef struct packed {
    ev_t         kind;
    logic [31:0] data;
  } ev_s;

  ev_s sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_t kind, input logic [31:0] data);
    ev_s e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input string name, input ev_t kind, input logic [31:0] act);
    ev_s e;
    check({name, "_expected"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(name, 64'({kind, act}), 64'({e.kind, e.data}));
    end
  endtask

  // Monitor: compare each rising request/drive and every READY change against the scoreboard
  bit   mon_en = 1'b0;
  logic p_rd = 1'b0, p_io = 1'b0, p_wr = 1'b0, p_oe = 1'b0, p_rdy = 1'b1;
  always @(negedge CLK2_I) begin
    if (mon_en) begin
      if (RD_O && !p_rd)     sb_pop("rd_req",  EV_RD,   {18'd0, ADDR_O});
      if (IO_O && !p_io)     sb_pop("io_req",  EV_IO,   {18'd0, IO_PORT_O, IO_OUT_O, WDAT_O});
      if (WR_O && !p_wr)     sb_pop("wr_req",  EV_WR,   {10'd0, ADDR_O, WDAT_O});
      if (READY_O != p_rdy)  sb_pop("ready",   EV_RDY,  {31'd0, READY_O});
      if (D_OE_O && !p_oe)   sb_pop("d_out",   EV_DOUT, {24'd0, D_O});
    end
    p_rd  <= RD_O;
    p_io  <= IO_O;
    p_wr  <= WR_O;
    p_oe  <= D_OE_O;
    p_rdy <= READY_O;
  end

  // One CPU T-state: S/D presented with SYNC high across a single rising edge
  task automatic bus(input logic [2:0] s, input logic [7:0] d);
    S_I = s;
    D_I = d;
    SYNC_I = 1'b1;
    @(posedge CLK2_I); #1;
    SYNC_I = 1'b0;
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge CLK2_I); #1;
    end
  endtask

  task automatic ack(input logic [7:0] d);
    RDAT_I = d;
    ACK_I = 1'b1;
    clk_n(1);
    ACK_I = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clk_n(3);
    check("rst_ready", 64'(READY_O), 64'(1));
    check("rst_rd",    64'(RD_O),    64'(0));
    check("rst_wr",    64'(WR_O),    64'(0));
    check("rst_io",    64'(IO_O),    64'(0));
    check("rst_oe",    64'(D_OE_O),  64'(0));
    check("rst_addr",  64'(ADDR_O),  64'(0));
    check("rst_wdat",  64'(WDAT_O),  64'(0));
    nRST_I = 1'b1;
    mon_en = 1'b1;
    clk_n(2);

    // Memory read 0x1234, ACK three clocks after T2, data A5
    bus(S_T1, 8'h34);
    expect_ev(EV_RD, 32'h1234);
    expect_ev(EV_RDY, 32'd0);
    bus(S_T2, 8'h52);
    check("rd_addr", 64'(ADDR_O), 64'(14'h1234));
    clk_n(2);
    check("rd_ready_low", 64'(READY_O), 64'(0));
    expect_ev(EV_RDY, 32'd1);
    ack(8'hA5);
    expect_ev(EV_DOUT, 32'hA5);
    bus(S_T3, 8'h00);
    bus(S_T4, 8'h00);
    check("rd_oe_release", 64'(D_OE_O), 64'(0));
    bus(S_T5, 8'h00);

    // Interrupt fetch: vector jammed, no memory request, no wait
    bus(S_T1I, 8'h00);
    bus(S_T2, 8'h00);
    check("int_no_rd", 64'(RD_O), 64'(0));
    check("int_ready", 64'(READY_O), 64'(1));
    expect_ev(EV_DOUT, 32'h0D);
    bus(S_T3, 8'h00);
    check("int_oe", 64'(D_OE_O), 64'(1));
    bus(S_T4, 8'h00);

    // I/O output to port 15 with accumulator 5A
    bus(S_T1, 8'h5A);
    expect_ev(EV_IO, {18'd0, 5'd15, 1'b1, 8'h5A});
    expect_ev(EV_RDY, 32'd0);
    bus(S_T2, 8'h9E);
    check("io_port", 64'(IO_PORT_O), 64'(15));
    expect_ev(EV_RDY, 32'd1);
    ack(8'h00);
    bus(S_T3, 8'h00);
    check("io_out_no_drive", 64'(D_OE_O), 64'(0));
    bus(S_T4, 8'h00);

    // Posted write to 0x0100, ACK ten clocks later across the next cycle's T1/T2
    bus(S_T1, 8'h00);
    bus(S_T2, 8'hC1);
    check("wr_addr", 64'(ADDR_O), 64'(14'h0100));
    check("wr_no_wait", 64'(READY_O), 64'(1));
    expect_ev(EV_WR, {10'd0, 14'h0100, 8'h77});
    bus(S_T3, 8'h77);
    clk_n(1);
    bus(S_T1, 8'h20);
    clk_n(1);
    expect_ev(EV_RDY, 32'd0);
    bus(S_T2, 8'hC2);
    clk_n(1);
    bus(S_WAIT, 8'h00);
    clk_n(3);
    check("pwr_held", 64'(WR_O), 64'(1));
    check("pwr_wdat", 64'(WDAT_O), 64'(8'h77));
    check("pwr_ready_low", 64'(READY_O), 64'(0));
    expect_ev(EV_RDY, 32'd1);
    ack(8'h00);
    check("pwr_wr_drop", 64'(WR_O), 64'(0));
    clk_n(1);
    check("next_addr", 64'(ADDR_O), 64'(14'h0220));
    expect_ev(EV_WR, {10'd0, 14'h0220, 8'h88});
    bus(S_T3, 8'h88);
    clk_n(1);
    ack(8'h00);
    check("wr2_done", 64'(WR_O), 64'(0));
    bus(S_T4, 8'h00);

    // Read with no ACK: completes on the fourth sample edge with FF
    bus(S_T1, 8'h10);
    expect_ev(EV_RD, 32'h0310);
    expect_ev(EV_RDY, 32'd0);
    bus(S_T2, 8'h43);
    bus(S_WAIT, 8'h00);
    bus(S_WAIT, 8'h00);
    bus(S_WAIT, 8'h00);
    check("tmo_still_wait", 64'(READY_O), 64'(0));
    expect_ev(EV_RDY, 32'd1);
    bus(S_WAIT, 8'h00);
    check("tmo_rd_drop", 64'(RD_O), 64'(0));
    expect_ev(EV_DOUT, 32'hFF);
    bus(S_T3, 8'h00);
    bus(S_T4, 8'h00);

    // T3 straight after T1 is illegal: cycle abandoned, stray T2 ignored
    bus(S_T1, 8'h11);
    bus(S_T3, 8'h00);
    bus(S_T2, 8'h52);
    check("illegal_no_rd", 64'(RD_O), 64'(0));
    check("illegal_ready", 64'(READY_O), 64'(1));

    // Asynchronous reset in the middle of a pending read
    bus(S_T1, 8'h55);
    expect_ev(EV_RD, 32'h0155);
    expect_ev(EV_RDY, 32'd0);
    bus(S_T2, 8'h41);
    clk_n(1);
    expect_ev(EV_RDY, 32'd1);
    #2 nRST_I = 1'b0;
    #1;
    check("arst_rd",    64'(RD_O),    64'(0));
    check("arst_ready", 64'(READY_O), 64'(1));
    check("arst_oe",    64'(D_OE_O),  64'(0));
    check("arst_addr",  64'(ADDR_O),  64'(0));
    clk_n(2);
    nRST_I = 1'b1;
    clk_n(1);
    bus(S_T1, 8'h66);
    expect_ev(EV_RD, 32'h0266);
    expect_ev(EV_RDY, 32'd0);
    bus(S_T2, 8'h42);
    expect_ev(EV_RDY, 32'd1);
    ack(8'h3C);
    expect_ev(EV_DOUT, 32'h3C);
    bus(S_T3, 8'h00);
    bus(S_T4, 8'h00);

    clk_n(3);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
